// File: rtl/flash_audio_pkg.sv
// Shared types and default song bounds for the flash audio reader blocks.
package flash_audio_pkg;

    localparam int FLASH_ADDR_W = 23;

    localparam logic [FLASH_ADDR_W-1:0] FLASH_START_ADDR = 23'h000000;
    localparam logic [FLASH_ADDR_W-1:0] FLASH_END_ADDR   = 23'h07FFFF;

    typedef enum logic [1:0] {
        WAIT_FIRST  = 2'd0,
        REQ         = 2'd1,
        WAIT_SECOND = 2'd2,
        ADVANCE     = 2'd3
    } fah_state_t;

endpackage

// File: rtl/flash_addr_counter.sv
// Bounded up/down word-address counter with wrap pulse and restart load.
module flash_addr_counter #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_load_bwd,
    input  logic              i_step,
    input  logic              i_step_bwd,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_wrapped
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr;
    logic              r_wrapped;
    logic              w_at_start;
    logic              w_at_end;

    // Bounds are compared before stepping, so the add/subtract never overflows.
    assign w_at_start = (r_addr == START_ADDR);
    assign w_at_end   = (r_addr == END_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= START_ADDR;
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= 1'b0;
            if (i_load) begin
                r_addr <= i_load_bwd ? END_ADDR : START_ADDR;
            end else if (i_step) begin
                if (i_step_bwd) begin
                    if (w_at_start) begin
                        r_addr    <= END_ADDR;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_addr <= r_addr - ONE;
                    end
                end else begin
                    if (w_at_end) begin
                        r_addr    <= START_ADDR;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_addr <= r_addr + ONE;
                    end
                end
            end
        end
    end

    assign o_addr    = r_addr;
    assign o_wrapped = r_wrapped;

endmodule

// File: rtl/flash_address_handler.sv
// Flash audio reader front end: owns the playback word address and issues one
// 32-bit read per two 16-bit samples, with pause, direction and restart control.
module flash_address_handler
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FLASH_START_ADDR),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(FLASH_END_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              play_en,
    input  logic              dir_bwd,
    input  logic              restart,
    input  logic              rd_done,
    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_address,
    output logic              half_sel,
    output logic              sample_strobe,
    output logic              wrapped,
    output logic              overrun,
    output logic [1:0]        state
);

    fah_state_t r_state;
    fah_state_t w_next_state;

    logic r_dir_q;
    logic r_pending;
    logic r_rd_start;
    logic r_half_sel;
    logic r_sample_strobe;
    logic r_overrun;

    logic w_dir_q_nxt;
    logic w_pending_nxt;
    logic w_half_sel_nxt;
    logic w_strobe_nxt;
    logic w_overrun_nxt;

    logic w_play_tick;
    logic w_apply_restart;
    logic w_step;

    assign w_play_tick = sample_tick & play_en;

    // A restart seen in REQ waits for rd_done so the outstanding read is never abandoned.
    assign w_apply_restart = (r_state == REQ) ? (rd_done & (r_pending | restart)) : restart;
    assign w_step          = (r_state == ADVANCE);

    flash_addr_counter #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_apply_restart),
        .i_load_bwd (dir_bwd),
        .i_step     (w_step),
        .i_step_bwd (r_dir_q),
        .o_addr     (rd_address),
        .o_wrapped  (wrapped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= WAIT_FIRST;
            r_dir_q         <= 1'b0;
            r_pending       <= 1'b0;
            r_rd_start      <= 1'b0;
            r_half_sel      <= 1'b0;
            r_sample_strobe <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_dir_q         <= w_dir_q_nxt;
            r_pending       <= w_pending_nxt;
            r_rd_start      <= (w_next_state == REQ);
            r_half_sel      <= w_half_sel_nxt;
            r_sample_strobe <= w_strobe_nxt;
            r_overrun       <= w_overrun_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_FIRST:  if (w_play_tick) w_next_state = REQ;
            REQ:         if (rd_done) w_next_state = (r_pending | restart) ? WAIT_FIRST : WAIT_SECOND;
            WAIT_SECOND: if (w_play_tick) w_next_state = ADVANCE;
            ADVANCE:     w_next_state = WAIT_FIRST;
            default:     w_next_state = WAIT_FIRST;
        endcase
        if (restart && (r_state != REQ)) w_next_state = WAIT_FIRST;
    end

    always_comb begin
        w_dir_q_nxt    = r_dir_q;
        w_pending_nxt  = r_pending;
        w_half_sel_nxt = r_half_sel;
        w_strobe_nxt   = 1'b0;
        w_overrun_nxt  = 1'b0;
        case (r_state)
            REQ: begin
                w_overrun_nxt = sample_tick;
                if (rd_done) begin
                    w_pending_nxt = 1'b0;
                    if (!(r_pending | restart)) begin
                        w_strobe_nxt   = 1'b1;
                        w_half_sel_nxt = r_dir_q;
                    end
                end else if (restart) begin
                    w_pending_nxt = 1'b1;
                end
            end
            WAIT_SECOND: begin
                if (w_play_tick && !restart) begin
                    w_strobe_nxt   = 1'b1;
                    w_half_sel_nxt = ~r_half_sel;
                end
            end
            ADVANCE:    w_dir_q_nxt = dir_bwd;
            default:    ;
        endcase
        if (w_apply_restart) begin
            w_half_sel_nxt = 1'b0;
            w_dir_q_nxt    = dir_bwd;
        end
    end

    assign rd_start      = r_rd_start;
    assign half_sel      = r_half_sel;
    assign sample_strobe = r_sample_strobe;
    assign overrun       = r_overrun;
    assign state         = r_state;

endmodule
